idwt_sched: RTL and testbench

IDWT_SCHED -- requirements
Module: idwt_sched

---
 rtl/idwt_sched_pkg.sv | 14 +
 rtl/idwt_sched_wt_delay.sv | 33 +++
 rtl/idwt_sched.sv | 182 ++++++++++++++++++
 tb/tb_idwt_sched.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idwt_sched_pkg.sv
// Shared wavelet definitions for the inverse-DWT scheduler slice.
//   pDB6    : zero-pair slots needed to flush a DB6 synthesis filter
//   state_e : scheduler states (idle, running a frame, flushing the filter)
package idwt_sched_pkg;

    localparam int unsigned pDB6 = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/idwt_sched_wt_delay.sv
// Fixed-latency shift register, cleared by reset.
//   i_clk   : clock
//   i_rst_n : async active-low reset, clears every stage
//   i_d     : word entering the line each cycle
//   o_q     : word that entered pDEPTH cycles earlier
module wt_delay #(
    parameter int unsigned pWIDTH = 1,
    parameter int unsigned pDEPTH = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [pWIDTH-1:0] i_d,
    output logic [pWIDTH-1:0] o_q
);

    logic [pWIDTH-1:0] r_pipe [pDEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < pDEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int unsigned i = 1; i < pDEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[pDEPTH-1];

endmodule

// File: rtl/idwt_sched.sv
// Inverse-DWT level scheduler: arbitrates per-level coefficient pairs onto a
// single synthesis core, zero-stuffs the odd filter slot, flushes the filter
// after each frame and tags the samples emerging from the core.
//   iclk / irst        : clock, async active-low reset
//   ireq_valid/last    : per-level pair valid and end-of-frame flag
//   ireq_datH/L        : per-level H/L coefficients, level k at [k*pWIDTH +: pWIDTH]
//   oreq_ready         : one-hot pair-accept strobe
//   ocore_clk_ena(x2)  : sample-rate / filter-rate strobes to the core
//   ocore_ena          : core enable (RUN or FLUSH)
//   ocore_datH/L       : coefficient pair to the core, zero except on accept
//   otag_valid/level   : real sample leaving the core and its level
//   obusy              : scheduler not idle
module idwt_sched
    import idwt_sched_pkg::*;
#(
    parameter int unsigned pWIDTH    = 12,
    parameter int unsigned pLEVELS   = 4,
    parameter int unsigned pDIV      = 2,
    parameter int unsigned pFLUSH    = pDB6,
    parameter int unsigned pCORE_LAT = 8
) (
    input  logic                       iclk,
    input  logic                       irst,
    input  logic [pLEVELS-1:0]         ireq_valid,
    input  logic [pLEVELS-1:0]         ireq_last,
    input  logic [pLEVELS*pWIDTH-1:0]  ireq_datH,
    input  logic [pLEVELS*pWIDTH-1:0]  ireq_datL,
    output logic [pLEVELS-1:0]         oreq_ready,
    output logic                       ocore_clk_ena,
    output logic                       ocore_clk_enax2,
    output logic                       ocore_ena,
    output logic [pWIDTH-1:0]          ocore_datH,
    output logic [pWIDTH-1:0]          ocore_datL,
    output logic                       otag_valid,
    output logic [$clog2(pLEVELS)-1:0] otag_level,
    output logic                       obusy
);

    localparam int unsigned LW = $clog2(pLEVELS);
    localparam int unsigned DW = (pDIV > 1) ? $clog2(pDIV) : 1;
    localparam int unsigned FW = (pFLUSH > 0) ? $clog2(pFLUSH + 1) : 1;

    state_e          r_state, w_state_nxt;
    logic [DW-1:0]   r_div;
    logic            r_slot;
    logic [FW-1:0]   r_flush, w_flush_nxt;
    logic [LW-1:0]   r_rr, w_rr_nxt;
    logic [LW-1:0]   r_grant, w_grant_nxt;

    logic            w_enax2;
    logic            w_data_slot;
    logic            w_any;
    logic [LW-1:0]   w_pick;
    logic [LW-1:0]   w_idx;
    logic            w_accept;
    logic [pWIDTH-1:0] w_selH, w_selL;
    logic [LW-1:0]   w_tag_lvl;
    logic [LW:0]     w_tag_in, w_tag_out;

    // Gated by irst so the strobe stays low in reset even when pDIV=1.
    assign w_enax2     = irst & (r_div == DW'(pDIV - 1));
    assign w_data_slot = w_enax2 & ~r_slot;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_div  <= '0;
            r_slot <= 1'b0;
        end else begin
            r_div <= (r_div == DW'(pDIV - 1)) ? '0 : r_div + 1'b1;
            if (w_enax2) begin
                r_slot <= ~r_slot;
            end
        end
    end

    // Round-robin search starting one past the last granted level.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr;
        w_idx  = '0;
        for (int unsigned i = 1; i <= pLEVELS; i++) begin
            w_idx = LW'((32'(r_rr) + i) % pLEVELS);
            if (!w_any && ireq_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_selH = '0;
        w_selL = '0;
        for (int unsigned k = 0; k < pLEVELS; k++) begin
            if (r_grant == LW'(k)) begin
                w_selH = ireq_datH[k*pWIDTH +: pWIDTH];
                w_selL = ireq_datL[k*pWIDTH +: pWIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        w_flush_nxt = r_flush;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_RUN;
                    w_grant_nxt = w_pick;
                end
            end
            ST_RUN: begin
                if (w_data_slot && ireq_valid[r_grant]) begin
                    w_accept = 1'b1;
                    if (ireq_last[r_grant]) begin
                        w_state_nxt = ST_FLUSH;
                        w_flush_nxt = FW'(pFLUSH);
                    end
                end
            end
            ST_FLUSH: begin
                if (w_data_slot) begin
                    if (r_flush <= FW'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_flush_nxt = '0;
                        w_rr_nxt    = r_grant;
                    end else begin
                        w_flush_nxt = r_flush - 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_state <= ST_IDLE;
            r_flush <= '0;
            r_rr    <= LW'(pLEVELS - 1);
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_flush_nxt;
            r_rr    <= w_rr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        oreq_ready = '0;
        for (int unsigned k = 0; k < pLEVELS; k++) begin
            oreq_ready[k] = w_accept && (r_grant == LW'(k));
        end
    end

    assign ocore_clk_enax2 = w_enax2;
    assign ocore_clk_ena   = w_data_slot;
    assign ocore_ena       = (r_state != ST_IDLE);
    assign obusy           = (r_state != ST_IDLE);
    assign ocore_datH      = w_accept ? w_selH : '0;
    assign ocore_datL      = w_accept ? w_selL : '0;

    assign w_tag_lvl = w_accept ? r_grant : LW'(0);
    assign w_tag_in  = {w_accept, w_tag_lvl};

    wt_delay #(
        .pWIDTH (LW + 1),
        .pDEPTH (pCORE_LAT)
    ) u_tag_dly (
        .i_clk   (iclk),
        .i_rst_n (irst),
        .i_d     (w_tag_in),
        .o_q     (w_tag_out)
    );

    assign otag_valid = w_tag_out[LW];
    assign otag_level = w_tag_out[LW-1:0];

endmodule

// File: tb/tb_idwt_sched.sv
`timescale 1ns/1ps
module tb_idwt_sched;

    localparam int unsigned W    = 12;
    localparam int unsigned LV   = 4;
    localparam int unsigned DIV  = 2;
    localparam int unsigned FL   = 12;
    localparam int unsigned LAT  = 8;
    localparam int unsigned LW   = 2;
    localparam int unsigned P    = 2 * DIV;
    localparam int unsigned MAXC = 2048;
    localparam int unsigned MAXP = 32;

    logic              iclk = 1'b0;
    logic              irst = 1'b1;
    logic [LV-1:0]     ireq_valid = '0;
    logic [LV-1:0]     ireq_last  = '0;
    logic [LV*W-1:0]   ireq_datH  = '0;
    logic [LV*W-1:0]   ireq_datL  = '0;
    logic [LV-1:0]     oreq_ready;
    logic              ocore_clk_ena, ocore_clk_enax2, ocore_ena;
    logic [W-1:0]      ocore_datH, ocore_datL;
    logic              otag_valid, obusy;
    logic [LW-1:0]     otag_level;

    idwt_sched #(
        .pWIDTH    (W),
        .pLEVELS   (LV),
        .pDIV      (DIV),
        .pFLUSH    (FL),
        .pCORE_LAT (LAT)
    ) dut (
        .iclk            (iclk),
        .irst            (irst),
        .ireq_valid      (ireq_valid),
        .ireq_last       (ireq_last),
        .ireq_datH       (ireq_datH),
        .ireq_datL       (ireq_datL),
        .oreq_ready      (oreq_ready),
        .ocore_clk_ena   (ocore_clk_ena),
        .ocore_clk_enax2 (ocore_clk_enax2),
        .ocore_ena       (ocore_ena),
        .ocore_datH      (ocore_datH),
        .ocore_datL      (ocore_datL),
        .otag_valid      (otag_valid),
        .otag_level      (otag_level),
        .obusy           (obusy)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic         last;
        logic [3:0]   pre;   // data slots held invalid before offering this pair
    } pair_t;

    typedef logic [LV+2*W+5+LW-1:0] vec_t;

    pair_t       pairs [LV][MAXP];
    int unsigned npairs [LV];

    vec_t          obs   [MAXC];
    logic [LV-1:0] e_rdy [MAXC];
    logic [W-1:0]  e_h   [MAXC];
    logic [W-1:0]  e_l   [MAXC];
    logic          e_busy[MAXC];
    logic          e_tv  [MAXC];
    logic [LW-1:0] e_tl  [MAXC];
    int unsigned   exp_order[$];
    int unsigned   obs_order[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic vec_t pack(logic [LV-1:0] r, logic [W-1:0] h, logic [W-1:0] l,
                                  logic x2, logic x1, logic en, logic bz,
                                  logic tv, logic [LW-1:0] tl);
        return {r, h, l, x2, x1, en, bz, tv, (tv ? tl : LW'(0))};
    endfunction

    task automatic clear_pairs();
        for (int unsigned k = 0; k < LV; k++) npairs[k] = 0;
    endtask

    task automatic add_pair(input int unsigned k, input logic [W-1:0] h, input logic [W-1:0] l,
                            input logic last, input int unsigned pre);
        pairs[k][npairs[k]] = '{h: h, l: l, last: last, pre: 4'(pre)};
        npairs[k]++;
    endtask

    // Transaction-level model: frames are granted round-robin, each pair lands
    // on successive data slots (plus requested bubbles), then pFLUSH data slots
    // of zeros, and the next grant is decided in the first idle cycle.
    task automatic build_model(output int unsigned t_end);
        int unsigned hd [LV];
        int unsigned rr, v, c, g;
        bit          found, done_frame;
        pair_t       p;
        for (int unsigned i = 0; i < MAXC; i++) begin
            e_rdy[i] = '0; e_h[i] = '0; e_l[i] = '0;
            e_busy[i] = 1'b0; e_tv[i] = 1'b0; e_tl[i] = '0;
        end
        exp_order.delete();
        for (int unsigned k = 0; k < LV; k++) hd[k] = 0;
        rr = LV - 1;
        v  = 0;
        forever begin
            found = 1'b0;
            g     = 0;
            for (int unsigned i = 1; i <= LV; i++) begin
                if (!found && hd[(rr + i) % LV] < npairs[(rr + i) % LV]) begin
                    found = 1'b1;
                    g     = (rr + i) % LV;
                end
            end
            if (!found) break;
            exp_order.push_back(g);
            c = v + 1;
            while (c % P != DIV - 1) c++;
            done_frame = 1'b0;
            while (!done_frame) begin
                p = pairs[g][hd[g]];
                hd[g]++;
                c += p.pre * P;
                e_rdy[c]      = LV'(1) << g;
                e_h[c]        = p.h;
                e_l[c]        = p.l;
                e_tv[c + LAT] = 1'b1;
                e_tl[c + LAT] = LW'(g);
                if (p.last || hd[g] >= npairs[g]) done_frame = 1'b1;
                else c += P;
            end
            c += P * FL;
            for (int unsigned i = v + 1; i <= c; i++) e_busy[i] = 1'b1;
            rr = g;
            v  = c + 1;
        end
        t_end = v + LAT + 2 * P;
    endtask

    // Enter with reset asserted, #1 after a rising edge; releases reset and
    // plays the pair lists for t_len cycles, recording the outputs per cycle.
    task automatic run_sched(input int unsigned t_len);
        int unsigned hd [LV];
        int unsigned hold [LV];
        bit          drive, in_frame;
        obs_order.delete();
        in_frame = 1'b0;
        for (int unsigned k = 0; k < LV; k++) begin
            hd[k] = 0;
            hold[k] = 0;
        end
        for (int unsigned c = 0; c < t_len; c++) begin
            for (int unsigned k = 0; k < LV; k++) begin
                drive = (hd[k] < npairs[k]) && (hold[k] == 0);
                if (hold[k] > 0) hold[k]--;
                ireq_valid[k] = drive;
                if (drive) begin
                    ireq_datH[k*W +: W] = pairs[k][hd[k]].h;
                    ireq_datL[k*W +: W] = pairs[k][hd[k]].l;
                    ireq_last[k]        = pairs[k][hd[k]].last;
                end else begin
                    ireq_datH[k*W +: W] = W'($urandom);
                    ireq_datL[k*W +: W] = W'($urandom);
                    ireq_last[k]        = 1'($urandom_range(0, 1));
                end
            end
            irst = 1'b1;
            @(negedge iclk);
            obs[c] = pack(oreq_ready, ocore_datH, ocore_datL, ocore_clk_enax2,
                          ocore_clk_ena, ocore_ena, obusy, otag_valid, otag_level);
            for (int unsigned k = 0; k < LV; k++) begin
                if (oreq_ready[k] && hd[k] < npairs[k]) begin
                    if (!in_frame) obs_order.push_back(k);
                    in_frame = !pairs[k][hd[k]].last;
                    hd[k]++;
                    if (hd[k] < npairs[k] && pairs[k][hd[k]].pre != 0)
                        hold[k] = pairs[k][hd[k]].pre * P;
                end
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic enter_reset(input int unsigned n);
        @(posedge iclk);
        #1;
        irst = 1'b0;
        repeat (n) begin
            ireq_valid = LV'($urandom);
            ireq_last  = LV'($urandom);
            ireq_datH  = {$urandom, $urandom};
            ireq_datL  = {$urandom, $urandom};
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(posedge iclk);
        #1;
        irst = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            ireq_valid = LV'($urandom);
            ireq_last  = LV'($urandom);
            ireq_datH  = {$urandom, $urandom};
            ireq_datL  = {$urandom, $urandom};
            @(negedge iclk);
            n_cmp++;
            if ({oreq_ready, ocore_clk_ena, ocore_clk_enax2, ocore_ena, ocore_datH,
                 ocore_datL, otag_valid, otag_level, obusy} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got ready=%h x1=%b x2=%b ena=%b H=%h L=%h tv=%b tl=%h busy=%b, expected all zero",
                         i, oreq_ready, ocore_clk_ena, ocore_clk_enax2, ocore_ena,
                         ocore_datH, ocore_datL, otag_valid, otag_level, obusy);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_strobes();
        int unsigned t_end;
        clear_pairs();
        build_model(t_end);
        t_end = 24;
        enter_reset(2);
        run_sched(t_end);
        for (int unsigned c = 0; c < t_end; c++) begin
            n_cmp++;
            if (obs[c] !== pack('0, '0, '0, (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                                1'b0, 1'b0, 1'b0, '0)) begin
                n_bad++;
                $display("FAIL strobes cycle %0d: got %h, expected x2=%b x1=%b rest 0",
                         c, obs[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1);
            end
        end
    endtask

    task automatic test_level2_frame();
        int unsigned t_end;
        vec_t e;
        clear_pairs();
        add_pair(2, W'(1), W'(-1), 1'b0, 0);
        add_pair(2, W'(2), W'(-2), 1'b0, 0);
        add_pair(2, W'(3), W'(-3), 1'b1, 0);
        build_model(t_end);
        enter_reset(2);
        run_sched(t_end);
        for (int unsigned c = 0; c < t_end; c++) begin
            e = pack(e_rdy[c], e_h[c], e_l[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                     e_busy[c], e_busy[c], e_tv[c], e_tl[c]);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL level2_frame cycle %0d: got %h, expected %h", c, obs[c], e);
            end
        end
        n_cmp++;
        if (obs_order.size() != 1 || obs_order[0] != 2) begin
            n_bad++;
            $display("FAIL level2_grant: got %0d frames (first %0d), expected 1 frame on level 2",
                     obs_order.size(), (obs_order.size() > 0) ? obs_order[0] : 99);
        end
    endtask

    task automatic test_round_robin();
        int unsigned t_end;
        int unsigned want [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        vec_t e;
        clear_pairs();
        for (int unsigned f = 0; f < 2; f++)
            for (int unsigned k = 0; k < LV; k++)
                add_pair(k, W'($urandom), W'($urandom), 1'b1, 0);
        build_model(t_end);
        enter_reset(2);
        run_sched(t_end);
        for (int unsigned c = 0; c < t_end; c++) begin
            e = pack(e_rdy[c], e_h[c], e_l[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                     e_busy[c], e_busy[c], e_tv[c], e_tl[c]);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL round_robin cycle %0d: got %h, expected %h", c, obs[c], e);
            end
        end
        for (int unsigned i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= obs_order.size() || obs_order[i] != want[i]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d, expected %0d", i,
                         (i < obs_order.size()) ? obs_order[i] : 99, want[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        int unsigned t_end;
        int unsigned lvl;
        vec_t e;
        clear_pairs();
        lvl = $urandom_range(0, LV - 1);
        add_pair(lvl, W'($urandom), W'($urandom), 1'b0, 0);
        add_pair(lvl, W'($urandom), W'($urandom), 1'b0, 2);
        add_pair(lvl, W'($urandom), W'($urandom), 1'b0, 0);
        add_pair(lvl, W'($urandom), W'($urandom), 1'b1, 1);
        for (int unsigned k = 0; k < LV; k++)
            if (k != lvl) add_pair(k, W'($urandom), W'($urandom), 1'b1, 0);
        build_model(t_end);
        enter_reset(2);
        run_sched(t_end);
        for (int unsigned c = 0; c < t_end; c++) begin
            e = pack(e_rdy[c], e_h[c], e_l[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                     e_busy[c], e_busy[c], e_tv[c], e_tl[c]);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL bubbles cycle %0d: got %h, expected %h", c, obs[c], e);
            end
        end
    endtask

    task automatic test_random();
        int unsigned t_end;
        int unsigned nf, np;
        vec_t e;
        for (int unsigned it = 0; it < 3; it++) begin
            clear_pairs();
            for (int unsigned k = 0; k < LV; k++) begin
                nf = $urandom_range(0, 2);
                for (int unsigned f = 0; f < nf; f++) begin
                    np = $urandom_range(1, 3);
                    for (int unsigned j = 0; j < np; j++)
                        add_pair(k, W'($urandom), W'($urandom), j == np - 1,
                                 (j == 0) ? 0 : $urandom_range(0, 2));
                end
            end
            build_model(t_end);
            enter_reset(2);
            run_sched(t_end);
            for (int unsigned c = 0; c < t_end; c++) begin
                e = pack(e_rdy[c], e_h[c], e_l[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                         e_busy[c], e_busy[c], e_tv[c], e_tl[c]);
                n_cmp++;
                if (obs[c] !== e) begin
                    n_bad++;
                    $display("FAIL random[%0d] cycle %0d: got %h, expected %h", it, c, obs[c], e);
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        int unsigned t_end;
        vec_t e;
        clear_pairs();
        add_pair(2, W'($urandom), W'($urandom), 1'b1, 0);
        build_model(t_end);
        enter_reset(2);
        run_sched(20);
        for (int unsigned c = 0; c < 20; c++) begin
            e = pack(e_rdy[c], e_h[c], e_l[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                     e_busy[c], e_busy[c], e_tv[c], e_tl[c]);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL pre_reset_flush cycle %0d: got %h, expected %h", c, obs[c], e);
            end
        end
        // Mid-FLUSH: assert reset between edges with every level requesting.
        ireq_valid = '1;
        irst = 1'b0;
        #1;
        for (int unsigned i = 0; i < 4; i++) begin
            n_cmp++;
            if ({oreq_ready, ocore_clk_ena, ocore_clk_enax2, ocore_ena, ocore_datH,
                 ocore_datL, otag_valid, otag_level, obusy} !== '0) begin
                n_bad++;
                $display("FAIL flush_reset_outputs step %0d: got ready=%h ena=%b busy=%b tv=%b H=%h, expected all zero",
                         i, oreq_ready, ocore_ena, obusy, otag_valid, ocore_datH);
            end
            @(negedge iclk);
        end
        @(posedge iclk);
        #1;
        clear_pairs();
        for (int unsigned k = 0; k < LV; k++)
            add_pair(k, W'($urandom), W'($urandom), 1'b1, 0);
        build_model(t_end);
        run_sched(t_end);
        for (int unsigned c = 0; c < t_end; c++) begin
            e = pack(e_rdy[c], e_h[c], e_l[c], (c % DIV) == DIV - 1, (c % P) == DIV - 1,
                     e_busy[c], e_busy[c], e_tv[c], e_tl[c]);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL post_reset cycle %0d: got %h, expected %h", c, obs[c], e);
            end
        end
        n_cmp++;
        if (obs_order.size() == 0 || obs_order[0] != 0) begin
            n_bad++;
            $display("FAIL post_reset_first_grant: got %0d, expected 0",
                     (obs_order.size() > 0) ? obs_order[0] : 99);
        end
    endtask

    initial begin
        test_reset();
        test_strobes();
        test_level2_frame();
        test_round_robin();
        test_bubbles();
        test_random();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
